spart_bus_ctrl: RTL and testbench

- Bus-side sequencer for the SPART, driving IOCS/IORW/IOADDR and the data byte.
- After reset it programs the baud generator divisor: low byte to address 10, then high byte to address 11.
- It then arbitrates the single SPART bus port between draining the receiver (RDA) and feeding the transmitter (TBR).
- It presents a one-entry receive holding register and a req/ack transmit port to the host logic.

---
 rtl/spart_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_spart_bus_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_ctrl.sv
// SPART bus sequencer: programs the baud divisor, then arbitrates
// the single SPART bus port between receive draining and transmit feeding.
module spart_bus_ctrl #(
  parameter logic [15:0] DIV0 = 16'd1301,
  parameter logic [15:0] DIV1 = 16'd650,
  parameter logic [15:0] DIV2 = 16'd325,
  parameter logic [15:0] DIV3 = 16'd162
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  input  logic [7:0] bus_rdata,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] bus_wdata,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       cfg_done
);

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_RD,
    RX_GUARD,
    TX_WR,
    TX_GUARD
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cfg_q, cfg_d;
  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        rxv_q, rxv_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        done_q, done_d;
  logic [1:0]  div_cfg;
  logic [15:0] div;

  // Low byte uses the live select (it is latched that same edge);
  // the high byte uses the latched copy so both halves agree.
  always_comb begin
    div_cfg = (state_q == CFG_LO) ? br_cfg : cfg_q;
    div     = DIV0;
    unique case (div_cfg)
      2'b00: div = DIV0;
      2'b01: div = DIV1;
      2'b10: div = DIV2;
      2'b11: div = DIV3;
    endcase
  end

  // Next state and next registered bus/host outputs.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    iocs_d  = 1'b0;
    iorw_d  = 1'b1;
    addr_d  = 2'b00;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rxv_d   = rxv_q;
    rxd_d   = rxd_q;
    done_d  = done_q;
    if (rxv_q && rx_ready) rxv_d = 1'b0;
    unique case (state_q)
      CFG_LO: begin
        iocs_d  = 1'b1;
        iorw_d  = 1'b0;
        addr_d  = 2'b10;
        wdata_d = div[7:0];
        cfg_d   = br_cfg;
        done_d  = 1'b0;
        state_d = CFG_HI;
      end
      CFG_HI: begin
        iocs_d  = 1'b1;
        iorw_d  = 1'b0;
        addr_d  = 2'b11;
        wdata_d = div[15:8];
        state_d = IDLE;
      end
      IDLE: begin
        if (br_cfg != cfg_q) begin
          done_d  = 1'b0;
          state_d = CFG_LO;
        end else begin
          done_d = 1'b1;
          if (rda && !rxv_q) state_d = RX_RD;
          else if (tx_req && tbr && done_q)
            state_d = TX_WR;
        end
      end
      RX_RD: begin
        iocs_d  = 1'b1;
        state_d = RX_GUARD;
      end
      RX_GUARD: begin
        rxv_d   = 1'b1;
        rxd_d   = bus_rdata;
        state_d = IDLE;
      end
      TX_WR: begin
        iocs_d  = 1'b1;
        iorw_d  = 1'b0;
        wdata_d = tx_data;
        ack_d   = 1'b1;
        state_d = TX_GUARD;
      end
      TX_GUARD: state_d = IDLE;
      default:  state_d = CFG_LO;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CFG_LO;
      cfg_q   <= 2'b00;
      iocs_q  <= 1'b0;
      iorw_q  <= 1'b1;
      addr_q  <= 2'b00;
      wdata_q <= 8'h00;
      ack_q   <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      iocs_q  <= iocs_d;
      iorw_q  <= iorw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      done_q  <= done_d;
    end
  end

  assign iocs      = iocs_q;
  assign iorw      = iorw_q;
  assign ioaddr    = addr_q;
  assign bus_wdata = wdata_q;
  assign tx_ack    = ack_q;
  assign rx_valid  = rxv_q;
  assign rx_data   = rxd_q;
  assign cfg_done  = done_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Bench for spart_bus_ctrl: bus transactions and received bytes
// are checked against scoreboard queues filled as stimulus is driven.
module tb_spart_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic [7:0] bus_rdata = 8'h00;
  logic       iocs, iorw, tx_ack;
  logic [1:0] ioaddr;
  logic [7:0] bus_wdata;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_valid, cfg_done;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;

  spart_bus_ctrl dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg),
    .rda(rda), .tbr(tbr), .bus_rdata(bus_rdata),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .bus_wdata(bus_wdata), .tx_req(tx_req),
    .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_t;

  bus_t       bq[$];
  logic [7:0] rq[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cyc = -1;
  int ack_cyc = -1;
  int acks = 0;
  logic       prev_iocs = 1'b0;
  logic [1:0] prev_addr = 2'b00;

  function automatic bus_t wr(input logic [1:0] a,
                              input logic [7:0] d);
    bus_t b;
    b.rw = 1'b0;
    b.addr = a;
    b.data = d;
    return b;
  endfunction

  function automatic bus_t rd();
    bus_t b;
    b.rw = 1'b1;
    b.addr = 2'b00;
    b.data = 8'h00;
    return b;
  endfunction

  // One clock; outputs sampled on the falling edge. Acts as the
  // SPART side too: a read drops rda, a data write drops tbr.
  task automatic cycle();
    bus_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (iocs) begin
      tests++;
      if (bq.size() == 0) begin
        fails++;
        $display("FAIL bus_unexpected rw=%0b addr=%0d data=%02h required=no_cycle",
                 iorw, ioaddr, bus_wdata);
      end else begin
        e = bq.pop_front();
        if (iorw !== e.rw || ioaddr !== e.addr ||
            (!e.rw && bus_wdata !== e.data)) begin
          fails++;
          $display("FAIL bus_cycle got rw=%0b addr=%0d data=%02h required rw=%0b addr=%0d data=%02h",
                   iorw, ioaddr, bus_wdata, e.rw, e.addr, e.data);
        end
      end
      if (iorw && ioaddr == 2'b00) begin
        rd_cyc = cyc;
        rda = 1'b0;
      end
      if (!iorw && ioaddr == 2'b00) tbr = 1'b0;
    end
    if (prev_iocs && iocs) begin
      tests++;
      if (!(prev_addr == 2'b10 && ioaddr == 2'b11)) begin
        fails++;
        $display("FAIL iocs_back_to_back addr %0d->%0d required guard",
                 prev_addr, ioaddr);
      end
    end
    if (tx_ack) begin
      acks++;
      ack_cyc = cyc;
      tests++;
      if (cfg_done !== 1'b1) begin
        fails++;
        $display("FAIL ack_before_cfg cfg_done=%0b required 1", cfg_done);
      end
    end
    prev_iocs = iocs;
    prev_addr = ioaddr;
  endtask

  task automatic wait_cfg(input string nm);
    int n = 0;
    while (!cfg_done && n < 12) begin
      cycle();
      n++;
    end
    tests++;
    if (cfg_done !== 1'b1 || iocs !== 1'b0) begin
      fails++;
      $display("FAIL %s cfg_done=%0b iocs=%0b required 1/0",
               nm, cfg_done, iocs);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    tests++;
    if ({iocs, iorw, ioaddr, bus_wdata, tx_ack,
         rx_valid, rx_data, cfg_done} !==
        {1'b0, 1'b1, 2'b00, 8'h00, 1'b0,
         1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL %s got cs=%0b rw=%0b a=%0d wd=%02h ack=%0b rv=%0b rd=%02h done=%0b required 0/1/0/00/0/0/00/0",
               nm, iocs, iorw, ioaddr, bus_wdata, tx_ack,
               rx_valid, rx_data, cfg_done);
    end
  endtask

  task automatic wait_rx(input string nm, input int lat);
    int n = 0;
    logic [7:0] e;
    while (!rx_valid && n < 12) begin
      cycle();
      n++;
    end
    tests++;
    if (n != lat) begin
      fails++;
      $display("FAIL %s_latency got %0d required %0d", nm, n, lat);
    end
    e = (rq.size() != 0) ? rq.pop_front() : 8'hxx;
    tests++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      fails++;
      $display("FAIL %s_data got v=%0b %02h required 1 %02h",
               nm, rx_valid, rx_data, e);
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    cycle();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset_values");
    bq.push_back(wr(2'b10, 8'h8A));
    bq.push_back(wr(2'b11, 8'h02));
    rst = 1'b1;
    repeat (3) cycle();
    tests++;
    if (cfg_done !== 1'b1 || iocs !== 1'b0 || bq.size() != 0) begin
      fails++;
      $display("FAIL cfg_sequence done=%0b iocs=%0b left=%0d required 1/0/0",
               cfg_done, iocs, bq.size());
    end
    repeat (2) cycle();
  endtask

  task automatic test_rx();
    bq.push_back(rd());
    rq.push_back(8'h55);
    rda = 1'b1;
    bus_rdata = 8'h55;
    wait_rx("rx_first", 3);
    rda = 1'b1;
    bus_rdata = 8'h66;
    repeat (6) cycle();
    tests++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      fails++;
      $display("FAIL rx_backpressure got v=%0b %02h required 1 55",
               rx_valid, rx_data);
    end
    bq.push_back(rd());
    rq.push_back(8'h66);
    consume();
    tests++;
    if (rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rx_clear got %0b required 0", rx_valid);
    end
    wait_rx("rx_second", 3);
    consume();
    repeat (2) cycle();
  endtask

  task automatic test_tx();
    int n = 0;
    int a0;
    bq.push_back(wr(2'b00, 8'hA3));
    tx_data = 8'hA3;
    tx_req = 1'b1;
    tbr = 1'b1;
    while (!tx_ack && n < 12) begin
      cycle();
      n++;
    end
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL tx_latency got %0d required 2", n);
    end
    tx_req = 1'b0;
    cycle();
    tests++;
    if (tx_ack !== 1'b0) begin
      fails++;
      $display("FAIL tx_ack_width got %0b required 0", tx_ack);
    end
    repeat (2) cycle();
    a0 = acks;
    tx_data = 8'h5A;
    tx_req = 1'b1;
    tbr = 1'b0;
    repeat (6) cycle();
    tests++;
    if (acks != a0) begin
      fails++;
      $display("FAIL tx_tbr_low acks=%0d required %0d", acks, a0);
    end
    bq.push_back(wr(2'b00, 8'h5A));
    tbr = 1'b1;
    n = 0;
    while (!tx_ack && n < 12) begin
      cycle();
      n++;
    end
    tx_req = 1'b0;
    tests++;
    if (acks != a0 + 1) begin
      fails++;
      $display("FAIL tx_resume acks=%0d required %0d", acks, a0 + 1);
    end
    repeat (3) cycle();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bq.push_back(rd());
    bq.push_back(wr(2'b00, 8'h7E));
    rq.push_back(8'hC3);
    rd_cyc = -1;
    ack_cyc = -1;
    rda = 1'b1;
    bus_rdata = 8'hC3;
    tx_data = 8'h7E;
    tx_req = 1'b1;
    tbr = 1'b1;
    while (ack_cyc < 0 && n < 15) begin
      cycle();
      n++;
    end
    tx_req = 1'b0;
    tests++;
    if (rd_cyc < 0 || ack_cyc - rd_cyc != 3) begin
      fails++;
      $display("FAIL rx_then_tx read@%0d ack@%0d required gap 3",
               rd_cyc, ack_cyc);
    end
    wait_rx("rx_then_tx", 0);
    consume();
    repeat (2) cycle();
  endtask

  task automatic test_reconfig();
    int n = 0;
    int a0 = acks;
    bq.push_back(wr(2'b10, 8'hA2));
    bq.push_back(wr(2'b11, 8'h00));
    bq.push_back(wr(2'b00, 8'h99));
    br_cfg = 2'b11;
    tx_data = 8'h99;
    tx_req = 1'b1;
    tbr = 1'b1;
    cycle();
    tests++;
    if (cfg_done !== 1'b0) begin
      fails++;
      $display("FAIL reconfig_done_drop got %0b required 0", cfg_done);
    end
    while (acks == a0 && n < 20) begin
      cycle();
      n++;
    end
    tx_req = 1'b0;
    repeat (2) cycle();
    tests++;
    if (bq.size() != 0 || cfg_done !== 1'b1 || acks != a0 + 1) begin
      fails++;
      $display("FAIL reconfig left=%0d done=%0b acks=%0d required 0/1/%0d",
               bq.size(), cfg_done, acks, a0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bq.push_back(rd());
    rd_cyc = -1;
    rda = 1'b1;
    bus_rdata = 8'hEE;
    while (rd_cyc < 0 && n < 12) begin
      cycle();
      n++;
    end
    tests++;
    if (rd_cyc < 0) begin
      fails++;
      $display("FAIL reset_mid_read no read cycle required one");
    end
    rst = 1'b0;
    #1;
    chk_reset_vals("reset_mid_async");
    rda = 1'b0;
    repeat (2) cycle();
    chk_reset_vals("reset_mid_hold");
    bq.push_back(wr(2'b10, 8'hA2));
    bq.push_back(wr(2'b11, 8'h00));
    rst = 1'b1;
    wait_cfg("reset_mid_recfg");
    tests++;
    if (rx_valid !== 1'b0 || bq.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_discard rv=%0b left=%0d required 0/0",
               rx_valid, bq.size());
    end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_back_to_back();
    test_reconfig();
    test_reset_mid();
    repeat (3) cycle();
    tests++;
    if (bq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain bus=%0d rx=%0d required 0/0",
               bq.size(), rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
